// File: rtl/text_console_writer.sv
// text_console_writer: character-stream front end for the text-mode display.
// Accepts ASCII bytes over a valid/ready handshake and tracks a cursor. It writes glyph codes
// into the screen RAM and handles CR, LF, backspace, line wrap, scroll-up and full clear.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   in_valid/in_ready/in_char  byte input handshake (in_ready is combinational)
//   clr_req                    one-cycle pulse: clear screen and home the cursor
//   wr_en/wr_x/wr_y/wr_char    screen RAM write port (registered)
//   rd_x/rd_y/rd_char          screen RAM read port, used only while scrolling (1-cycle latency)
//   cursor_x/cursor_y          current cursor position
//   busy                       scrolling or clearing
module text_console_writer #(
  parameter int unsigned COLS  = 80,
  parameter int unsigned ROWS  = 30,
  parameter int unsigned XW    = 8,
  parameter int unsigned YW    = 7,
  parameter logic [7:0]  BLANK = 8'h20
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_char,
  input  logic          clr_req,
  output logic          wr_en,
  output logic [XW-1:0] wr_x,
  output logic [YW-1:0] wr_y,
  output logic [7:0]    wr_char,
  output logic [XW-1:0] rd_x,
  output logic [YW-1:0] rd_y,
  input  logic [7:0]    rd_char,
  output logic [XW-1:0] cursor_x,
  output logic [YW-1:0] cursor_y,
  output logic          busy
);

  localparam logic [XW-1:0] LAST_X = XW'(COLS - 1);
  localparam logic [YW-1:0] LAST_Y = YW'(ROWS - 1);

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCROLL_CP,
    S_SCROLL_CLR,
    S_CLEAR
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [XW-1:0] r_cx, w_cx_nxt;
  logic [YW-1:0] r_cy, w_cy_nxt;
  logic          r_wr_en, w_wr_en_nxt;
  logic [XW-1:0] r_wr_x, w_wr_x_nxt;
  logic [YW-1:0] r_wr_y, w_wr_y_nxt;
  logic [7:0]    r_wr_char, w_wr_char_nxt;
  logic [XW-1:0] r_rd_x, w_rd_x_nxt;
  logic [YW-1:0] r_rd_y, w_rd_y_nxt;
  logic          r_rd_act, w_rd_act_nxt;   // a read address is being presented this cycle
  logic          r_pend, w_pend_nxt;       // rd_char this cycle answers last cycle's read
  logic [XW-1:0] r_px, w_px_nxt;           // address of last cycle's read
  logic [YW-1:0] r_py, w_py_nxt;
  logic [XW-1:0] r_clr_x, w_clr_x_nxt;     // blanking sweep position
  logic [YW-1:0] r_clr_y, w_clr_y_nxt;

  assign in_ready = (r_state == S_IDLE) & ~clr_req;
  assign busy     = (r_state != S_IDLE);
  assign wr_en    = r_wr_en;
  assign wr_x     = r_wr_x;
  assign wr_y     = r_wr_y;
  assign wr_char  = r_wr_char;
  assign rd_x     = r_rd_x;
  assign rd_y     = r_rd_y;
  assign cursor_x = r_cx;
  assign cursor_y = r_cy;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cx      <= '0;
      r_cy      <= '0;
      r_wr_en   <= 1'b0;
      r_wr_x    <= '0;
      r_wr_y    <= '0;
      r_wr_char <= BLANK;
      r_rd_x    <= '0;
      r_rd_y    <= '0;
      r_rd_act  <= 1'b0;
      r_pend    <= 1'b0;
      r_px      <= '0;
      r_py      <= '0;
      r_clr_x   <= '0;
      r_clr_y   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cx      <= w_cx_nxt;
      r_cy      <= w_cy_nxt;
      r_wr_en   <= w_wr_en_nxt;
      r_wr_x    <= w_wr_x_nxt;
      r_wr_y    <= w_wr_y_nxt;
      r_wr_char <= w_wr_char_nxt;
      r_rd_x    <= w_rd_x_nxt;
      r_rd_y    <= w_rd_y_nxt;
      r_rd_act  <= w_rd_act_nxt;
      r_pend    <= w_pend_nxt;
      r_px      <= w_px_nxt;
      r_py      <= w_py_nxt;
      r_clr_x   <= w_clr_x_nxt;
      r_clr_y   <= w_clr_y_nxt;
    end
  end

  // Next-state and output decode
  always_comb begin
    w_state_nxt   = r_state;
    w_cx_nxt      = r_cx;
    w_cy_nxt      = r_cy;
    w_wr_en_nxt   = 1'b0;
    w_wr_x_nxt    = r_wr_x;
    w_wr_y_nxt    = r_wr_y;
    w_wr_char_nxt = r_wr_char;
    w_rd_x_nxt    = r_rd_x;
    w_rd_y_nxt    = r_rd_y;
    w_rd_act_nxt  = r_rd_act;
    w_pend_nxt    = 1'b0;
    w_px_nxt      = r_px;
    w_py_nxt      = r_py;
    w_clr_x_nxt   = r_clr_x;
    w_clr_y_nxt   = r_clr_y;

    unique case (r_state)
      S_IDLE: begin
        if (clr_req) begin
          w_state_nxt = S_CLEAR;
          w_cx_nxt    = '0;
          w_cy_nxt    = '0;
          w_clr_x_nxt = '0;
          w_clr_y_nxt = '0;
        end else if (in_valid) begin
          if (in_char >= 8'h20 && in_char <= 8'h7E) begin
            w_wr_en_nxt   = 1'b1;
            w_wr_x_nxt    = r_cx;
            w_wr_y_nxt    = r_cy;
            w_wr_char_nxt = in_char;
            if (r_cx == LAST_X) begin
              w_cx_nxt = '0;
              if (r_cy == LAST_Y) begin
                w_state_nxt  = S_SCROLL_CP;
                w_rd_x_nxt   = '0;
                w_rd_y_nxt   = YW'(1);
                w_rd_act_nxt = 1'b1;
              end else begin
                w_cy_nxt = r_cy + YW'(1);
              end
            end else begin
              w_cx_nxt = r_cx + XW'(1);
            end
          end else if (in_char == CH_CR) begin
            w_cx_nxt = '0;
          end else if (in_char == CH_LF) begin
            w_cx_nxt = '0;
            if (r_cy == LAST_Y) begin
              w_state_nxt  = S_SCROLL_CP;
              w_rd_x_nxt   = '0;
              w_rd_y_nxt   = YW'(1);
              w_rd_act_nxt = 1'b1;
            end else begin
              w_cy_nxt = r_cy + YW'(1);
            end
          end else if (in_char == CH_BS) begin
            // No reverse wrap: backspace at column 0 does nothing
            if (r_cx != '0) begin
              w_cx_nxt      = r_cx - XW'(1);
              w_wr_en_nxt   = 1'b1;
              w_wr_x_nxt    = r_cx - XW'(1);
              w_wr_y_nxt    = r_cy;
              w_wr_char_nxt = BLANK;
            end
          end
        end
      end

      // Raster read of rows 1..ROWS-1; each answer is written one row up on the following cycle
      S_SCROLL_CP: begin
        w_pend_nxt = r_rd_act;
        w_px_nxt   = r_rd_x;
        w_py_nxt   = r_rd_y;
        if (r_rd_act) begin
          if (r_rd_x == LAST_X) begin
            w_rd_x_nxt = '0;
            if (r_rd_y == LAST_Y) begin
              w_rd_act_nxt = 1'b0;
              w_rd_y_nxt   = '0;
            end else begin
              w_rd_y_nxt = r_rd_y + YW'(1);
            end
          end else begin
            w_rd_x_nxt = r_rd_x + XW'(1);
          end
        end
        if (r_pend) begin
          w_wr_en_nxt   = 1'b1;
          w_wr_x_nxt    = r_px;
          w_wr_y_nxt    = r_py - YW'(1);
          w_wr_char_nxt = rd_char;
        end
        // Reads finished: this is the drain cycle for the last answer
        if (!r_rd_act) begin
          w_state_nxt = S_SCROLL_CLR;
          w_clr_x_nxt = '0;
        end
      end

      S_SCROLL_CLR: begin
        w_wr_en_nxt   = 1'b1;
        w_wr_x_nxt    = r_clr_x;
        w_wr_y_nxt    = LAST_Y;
        w_wr_char_nxt = BLANK;
        if (r_clr_x == LAST_X) begin
          w_state_nxt = S_IDLE;
          w_clr_x_nxt = '0;
        end else begin
          w_clr_x_nxt = r_clr_x + XW'(1);
        end
      end

      S_CLEAR: begin
        w_wr_en_nxt   = 1'b1;
        w_wr_x_nxt    = r_clr_x;
        w_wr_y_nxt    = r_clr_y;
        w_wr_char_nxt = BLANK;
        if (r_clr_x == LAST_X) begin
          w_clr_x_nxt = '0;
          if (r_clr_y == LAST_Y) begin
            w_state_nxt = S_IDLE;
            w_clr_y_nxt = '0;
          end else begin
            w_clr_y_nxt = r_clr_y + YW'(1);
          end
        end else begin
          w_clr_x_nxt = r_clr_x + XW'(1);
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_text_console_writer.sv
// Testbench for text_console_writer: screen RAM model, table-driven byte vectors, and
// hand-written sequences for wrap, scroll, clear, backspace and reset-mid-scroll.
module tb_text_console_writer;

  localparam int COLS = 80;
  localparam int ROWS = 30;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_char = 8'h00;
  logic       clr_req = 1'b0;
  logic       wr_en;
  logic [7:0] wr_x;
  logic [6:0] wr_y;
  logic [7:0] wr_char;
  logic [7:0] rd_x;
  logic [6:0] rd_y;
  logic [7:0] rd_char;
  logic [7:0] cursor_x;
  logic [6:0] cursor_y;
  logic       busy;

  text_console_writer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_char(in_char),
    .clr_req(clr_req), .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_char(wr_char),
    .rd_x(rd_x), .rd_y(rd_y), .rd_char(rd_char), .cursor_x(cursor_x), .cursor_y(cursor_y),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Screen RAM model: preloaded with a pattern on the first edge, registered read
  logic [7:0] mem [0:ROWS-1][0:COLS-1];
  logic [7:0] snap [0:ROWS-1][0:COLS-1];
  logic       mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int y = 0; y < ROWS; y++)
        for (int x = 0; x < COLS; x++)
          mem[y][x] <= 8'((y * COLS + x) % 251 + 1);
      mem_init <= 1'b1;
    end else if (wr_en) begin
      mem[wr_y][wr_x] <= wr_char;
    end
    rd_char <= mem[rd_y][rd_x];
  end

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] ch);
    in_valid = 1'b1;
    in_char  = ch;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  typedef struct {
    logic [7:0] ch;
    logic       ew;
    logic [7:0] ex;
    logic [6:0] ey;
    logic [7:0] ec;
    logic [7:0] ecx;
    logic [6:0] ecy;
  } vec_t;

  vec_t vecs [13];

  initial begin
    int guard, cnt, bad, nwr, bc;
    logic ready_seen;

    vecs[0]  = '{8'h41, 1'b1, 8'd0, 7'd0, 8'h41, 8'd1, 7'd0};
    vecs[1]  = '{8'h42, 1'b1, 8'd1, 7'd0, 8'h42, 8'd2, 7'd0};
    vecs[2]  = '{8'h0D, 1'b0, 8'd0, 7'd0, 8'h00, 8'd0, 7'd0};
    vecs[3]  = '{8'h0A, 1'b0, 8'd0, 7'd0, 8'h00, 8'd0, 7'd1};
    vecs[4]  = '{8'h63, 1'b1, 8'd0, 7'd1, 8'h63, 8'd1, 7'd1};
    vecs[5]  = '{8'h08, 1'b1, 8'd0, 7'd1, 8'h20, 8'd0, 7'd1};
    vecs[6]  = '{8'h08, 1'b0, 8'd0, 7'd0, 8'h00, 8'd0, 7'd1};
    vecs[7]  = '{8'h7F, 1'b0, 8'd0, 7'd0, 8'h00, 8'd0, 7'd1};
    vecs[8]  = '{8'h1B, 1'b0, 8'd0, 7'd0, 8'h00, 8'd0, 7'd1};
    vecs[9]  = '{8'h7E, 1'b1, 8'd0, 7'd1, 8'h7E, 8'd1, 7'd1};
    vecs[10] = '{8'h20, 1'b1, 8'd1, 7'd1, 8'h20, 8'd2, 7'd1};
    vecs[11] = '{8'h0A, 1'b0, 8'd0, 7'd0, 8'h00, 8'd0, 7'd2};
    vecs[12] = '{8'h80, 1'b0, 8'd0, 7'd0, 8'h00, 8'd0, 7'd2};

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cursor", {16'(cursor_x), 16'(cursor_y)}, 32'd0);
    chk("rst_wr_char", 32'(wr_char), 32'h20);
    chk("rst_addr", {8'(wr_x), 8'(wr_y), 8'(rd_x), 8'(rd_y)}, 32'd0);
    rst_n = 1'b1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Table-driven single bytes, back-to-back
    for (int i = 0; i < 13; i++) begin
      in_valid = 1'b1;
      in_char  = vecs[i].ch;
      chk($sformatf("v%0d_ready", i), 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk($sformatf("v%0d_wr_en", i), 32'(wr_en), 32'(vecs[i].ew));
      if (vecs[i].ew)
        chk($sformatf("v%0d_wr", i), {8'(wr_x), 8'(wr_y), wr_char},
            {8'(vecs[i].ex), 8'(vecs[i].ey), vecs[i].ec});
      chk($sformatf("v%0d_cursor", i), {16'(cursor_x), 16'(cursor_y)},
          {16'(vecs[i].ecx), 16'(vecs[i].ecy)});
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'd0);
    end

    // 80 'x' back-to-back from (0,5): one write per cycle, wrap to (0,6)
    repeat (3) send_byte(8'h0A);
    chk("pre80_cursor", {16'(cursor_x), 16'(cursor_y)}, {16'd0, 16'd5});
    bad = 0;
    in_valid = 1'b1;
    in_char  = 8'h78;
    for (int i = 0; i < COLS; i++) begin
      @(posedge clk); #1;
      if (!(wr_en && wr_x == 8'(i) && wr_y == 7'd5 && wr_char == 8'h78)) bad++;
    end
    in_valid = 1'b0;
    chk("row80_bad_writes", 32'(bad), 32'd0);
    chk("row80_cursor", {16'(cursor_x), 16'(cursor_y)}, {16'd0, 16'd6});

    // Scroll: move to (3,29), snapshot the RAM, then LF
    repeat (23) send_byte(8'h0A);
    send_byte(8'h61);
    send_byte(8'h62);
    send_byte(8'h63);
    chk("prescroll_cursor", {16'(cursor_x), 16'(cursor_y)}, {16'd3, 16'd29});
    @(posedge clk); #1;
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++)
        snap[y][x] = mem[y][x];
    send_byte(8'h0A);
    cnt = 0; guard = 0; ready_seen = 1'b0;
    while (busy && guard < 5000) begin
      if (in_ready) ready_seen = 1'b1;
      cnt++; guard++;
      @(posedge clk); #1;
    end
    chk("scroll_timeout", 32'(guard < 5000), 32'd1);
    chk("scroll_busy_cycles", 32'(cnt), 32'd2401);
    chk("scroll_in_ready_low", 32'(ready_seen), 32'd0);
    chk("scroll_cursor", {16'(cursor_x), 16'(cursor_y)}, {16'd0, 16'd29});
    @(posedge clk); #1;
    for (int r = 0; r < ROWS; r++) begin
      bc = 0;
      for (int c = COLS - 1; c >= 0; c--) begin
        logic [7:0] e;
        e = (r == ROWS - 1) ? 8'h20 : snap[r+1][c];
        if (mem[r][c] !== e) bc = c;
      end
      chk($sformatf("scroll_row%0d_col%0d", r, bc), 32'(mem[r][bc]),
          32'((r == ROWS - 1) ? 8'h20 : snap[r+1][bc]));
    end
    chk("scroll_row28_abc", {8'h0, mem[28][0], mem[28][1], mem[28][2]}, 32'h00616263);
    chk("scroll_row5_x", 32'(mem[4][79]), 32'h78);

    // Clear together with a byte: clear wins, byte waits
    clr_req  = 1'b1;
    in_valid = 1'b1;
    in_char  = 8'h42;
    #1;
    chk("clr_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    clr_req = 1'b0;
    chk("clr_cursor_home", {16'(cursor_x), 16'(cursor_y)}, 32'd0);
    cnt = 0; nwr = 0; bad = 0; guard = 0;
    while (busy && guard < 5000) begin
      if (in_ready) bad++;
      if (wr_en) begin
        if (!(wr_x == 8'(nwr % COLS) && wr_y == 7'(nwr / COLS) && wr_char == 8'h20)) bad++;
        nwr++;
      end
      cnt++; guard++;
      @(posedge clk); #1;
    end
    chk("clr_timeout", 32'(guard < 5000), 32'd1);
    if (wr_en) begin
      if (!(wr_x == 8'(nwr % COLS) && wr_y == 7'(nwr / COLS) && wr_char == 8'h20)) bad++;
      nwr++;
    end
    chk("clr_busy_cycles", 32'(cnt), 32'd2400);
    chk("clr_write_count", 32'(nwr), 32'd2400);
    chk("clr_order_errs", 32'(bad), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("clr_B_write", {7'h0, wr_en, 8'(wr_x), 8'(wr_y), wr_char}, {7'h0, 1'b1, 8'd0, 8'd0, 8'h42});
    chk("clr_B_cursor", {16'(cursor_x), 16'(cursor_y)}, {16'd1, 16'd0});

    // Backspace at column 0 and mid-line
    send_byte(8'h0D);
    repeat (4) send_byte(8'h0A);
    send_byte(8'h08);
    chk("bs0_wr_en", 32'(wr_en), 32'd0);
    chk("bs0_cursor", {16'(cursor_x), 16'(cursor_y)}, {16'd0, 16'd4});
    repeat (7) send_byte(8'h71);
    chk("pre_bs7_cursor", {16'(cursor_x), 16'(cursor_y)}, {16'd7, 16'd4});
    send_byte(8'h08);
    chk("bs7_write", {7'h0, wr_en, 8'(wr_x), 8'(wr_y), wr_char}, {7'h0, 1'b1, 8'd6, 8'd4, 8'h20});
    chk("bs7_cursor", {16'(cursor_x), 16'(cursor_y)}, {16'd6, 16'd4});

    // Reset in the middle of a scroll copy
    repeat (25) send_byte(8'h0A);
    chk("pre_rst_cursor", {16'(cursor_x), 16'(cursor_y)}, {16'd0, 16'd29});
    send_byte(8'h0A);
    repeat (100) @(posedge clk);
    #1;
    chk("midscroll_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_wr_en", 32'(wr_en), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_cursor", {16'(cursor_x), 16'(cursor_y)}, 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    send_byte(8'h5A);
    chk("post_rst_write", {7'h0, wr_en, 8'(wr_x), 8'(wr_y), wr_char}, {7'h0, 1'b1, 8'd0, 8'd0, 8'h5A});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
